// File: rtl/apu_pulse_channel.sv
// Pulse (square-wave) voice modelled on the 2A03 APU: CPU/APU tick generation,
// duty sequencer, envelope, length counter and a frame sequencer for quarter/half frames.
module apu_pulse_channel #(
  parameter int CPU_DIV   = 12,
  parameter int FRAME_DIV = 7457
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       reg_we,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       enable,
  output logic [3:0] sample,
  output logic       sample_valid,
  output logic       length_active
);

  localparam int PW = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(CPU_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);

  logic [PW-1:0] prescaler_reg;
  logic          apu_phase_reg;
  logic [FW-1:0] frame_cnt_reg;
  logic          half_phase_reg;
  logic [10:0]   timer_reg;
  logic [10:0]   period_reg;
  logic [2:0]    step_reg;
  logic [1:0]    duty_reg;
  logic          halt_reg;
  logic          const_vol_reg;
  logic [3:0]    vol_reg;
  logic [7:0]    len_reg;
  logic          env_start_reg;
  logic [3:0]    env_div_reg;
  logic [3:0]    decay_reg;
  logic [3:0]    sample_reg;
  logic          sample_valid_reg;

  logic cpu_tick, apu_tick, quarter_frame, half_frame;
  logic wr_ctrl, wr_lo, wr_hi;
  logic duty_on, muted;

  function automatic logic [7:0] len_table(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
      5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
      5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
      5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
      5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
      5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
    endcase
    return v;
  endfunction

  // Patterns are written step0..step7 from MSB to LSB, so step s reads bit 7-s.
  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
    logic [7:0] pattern;
    case (duty)
      2'd0:    pattern = 8'b0100_0000;
      2'd1:    pattern = 8'b0110_0000;
      2'd2:    pattern = 8'b0111_1000;
      default: pattern = 8'b1001_1111;
    endcase
    return pattern[3'd7 - step];
  endfunction

  assign cpu_tick      = (prescaler_reg == PRE_LAST);
  assign apu_tick      = cpu_tick && apu_phase_reg;
  assign quarter_frame = cpu_tick && (frame_cnt_reg == FRAME_LAST);
  assign half_frame    = quarter_frame && half_phase_reg;

  assign wr_ctrl = reg_we && (reg_addr == 2'd0);
  assign wr_lo   = reg_we && (reg_addr == 2'd2);
  assign wr_hi   = reg_we && (reg_addr == 2'd3);

  assign duty_on = duty_bit(duty_reg, step_reg);
  assign muted   = (len_reg == 8'd0) || (period_reg[10:3] == 8'd0) || !duty_on;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      prescaler_reg  <= '0;
      apu_phase_reg  <= 1'b0;
      frame_cnt_reg  <= '0;
      half_phase_reg <= 1'b0;
    end else begin
      if (cpu_tick) begin
        prescaler_reg <= '0;
        apu_phase_reg <= ~apu_phase_reg;
        if (frame_cnt_reg == FRAME_LAST) begin
          frame_cnt_reg  <= '0;
          half_phase_reg <= ~half_phase_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
      end else begin
        prescaler_reg <= prescaler_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      duty_reg      <= 2'd0;
      halt_reg      <= 1'b0;
      const_vol_reg <= 1'b0;
      vol_reg       <= 4'd0;
      period_reg    <= 11'd0;
    end else begin
      if (wr_ctrl) begin
        duty_reg      <= reg_wdata[7:6];
        halt_reg      <= reg_wdata[5];
        const_vol_reg <= reg_wdata[4];
        vol_reg       <= reg_wdata[3:0];
      end
      if (wr_lo) period_reg[7:0]  <= reg_wdata;
      if (wr_hi) period_reg[10:8] <= reg_wdata[2:0];
    end
  end

  // A high-byte write restarts the waveform at step 0 but leaves the timer running.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      timer_reg <= 11'd0;
      step_reg  <= 3'd0;
    end else begin
      if (apu_tick) begin
        if (timer_reg == 11'd0) begin
          timer_reg <= period_reg;
          step_reg  <= step_reg + 3'd1;
        end else begin
          timer_reg <= timer_reg - 11'd1;
        end
      end
      if (wr_hi) step_reg <= 3'd0;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      env_start_reg <= 1'b0;
      env_div_reg   <= 4'd0;
      decay_reg     <= 4'd0;
    end else begin
      if (quarter_frame) begin
        if (env_start_reg) begin
          env_start_reg <= 1'b0;
          decay_reg     <= 4'd15;
          env_div_reg   <= vol_reg;
        end else if (env_div_reg == 4'd0) begin
          env_div_reg <= vol_reg;
          if (decay_reg != 4'd0) decay_reg <= decay_reg - 4'd1;
          else if (halt_reg)     decay_reg <= 4'd15;
        end else begin
          env_div_reg <= env_div_reg - 4'd1;
        end
      end
      if (wr_hi) env_start_reg <= 1'b1;
    end
  end

  // Disable beats a load, and a load beats a coincident half-frame decrement.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      len_reg <= 8'd0;
    end else if (!enable) begin
      len_reg <= 8'd0;
    end else if (wr_hi) begin
      len_reg <= len_table(reg_wdata[7:3]);
    end else if (half_frame && !halt_reg && (len_reg != 8'd0)) begin
      len_reg <= len_reg - 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      sample_reg       <= 4'd0;
      sample_valid_reg <= 1'b0;
    end else begin
      sample_valid_reg <= cpu_tick;
      if (cpu_tick) sample_reg <= muted ? 4'd0 : (const_vol_reg ? vol_reg : decay_reg);
    end
  end

  assign sample        = sample_reg;
  assign sample_valid  = sample_valid_reg;
  assign length_active = (len_reg != 8'd0);

endmodule

// File: tb/tb_apu_pulse_channel.sv
// Directed bench for apu_pulse_channel with shortened dividers so envelope and
// length behaviour can be observed in a few tens of thousands of clocks.
module tb_apu_pulse_channel;
  localparam int CPU_DIV   = 4;
  localparam int FRAME_DIV = 200;
  localparam int QF        = FRAME_DIV * CPU_DIV;        // CLKs per quarter frame
  localparam int HF        = 2 * QF;                     // CLKs per half frame
  localparam int STEP16    = (16 + 1) * 2 * CPU_DIV;     // CLKs per step at period 0x10

  logic       CLK;
  logic       reset_n;
  logic       reg_we;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       enable;
  logic [3:0] sample;
  logic       sample_valid;
  logic       length_active;

  int tests;
  int fails;

  apu_pulse_channel #(.CPU_DIV(CPU_DIV), .FRAME_DIV(FRAME_DIV)) dut (
    .CLK(CLK), .reset_n(reset_n), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .enable(enable), .sample(sample),
    .sample_valid(sample_valid), .length_active(length_active)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Called at a negedge; the write is captured by the following posedge.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge CLK);
    reg_we = 1'b0;
    $display("[TB] write addr=%0d data=0x%02h", a, d);
  endtask

  task automatic do_reset();
    @(negedge CLK); reset_n = 1'b0;
    repeat (2) @(negedge CLK);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; reg_we = 1'b0; reg_addr = 2'd0; reg_wdata = 8'd0;
    #2;
    tests++; if (sample !== 4'd0) begin fails++; $display("FAIL reset_sample got=%0d exp=0", sample); end
    tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
    tests++; if (length_active !== 1'b0) begin fails++; $display("FAIL reset_len got=%b exp=0", length_active); end
    repeat (3) @(negedge CLK);
    reset_n = 1'b1;
    for (int i = 1; i <= CPU_DIV; i++) begin
      @(negedge CLK);
      tests++;
      if (sample_valid !== (i == CPU_DIV)) begin
        fails++; $display("FAIL reset_first_tick clk=%0d got=%b exp=%b", i, sample_valid, i == CPU_DIV);
      end
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_duty_pattern();
    int k;
    wr(2'd0, 8'hBF); wr(2'd2, 8'h10); wr(2'd3, 8'h08);
    tests++; if (length_active !== 1'b1) begin fails++; $display("FAIL duty_len got=%b exp=1", length_active); end
    k = 0;
    while (sample === 4'd0 && k < 3000) begin @(negedge CLK); k++; end
    tests++; if (sample !== 4'd15) begin fails++; $display("FAIL duty_level got=%0d exp=15", sample); end
    k = 0;
    while (sample === 4'd15 && k < 3000) begin @(negedge CLK); k++; end
    tests++; if (k != 4 * STEP16) begin fails++; $display("FAIL duty_high_len got=%0d exp=%0d", k, 4 * STEP16); end
    k = 0;
    while (sample === 4'd0 && k < 3000) begin @(negedge CLK); k++; end
    tests++; if (k != 4 * STEP16) begin fails++; $display("FAIL duty_low_len got=%0d exp=%0d", k, 4 * STEP16); end
    $display("[TB] test_duty_pattern done");
  endtask

  task automatic test_period_mute();
    int nz, pulses;
    wr(2'd0, 8'hB9); wr(2'd2, 8'h05); wr(2'd3, 8'h08);
    repeat (CPU_DIV + 1) @(negedge CLK);
    nz = 0; pulses = 0;
    repeat (100 * CPU_DIV) begin
      @(negedge CLK);
      if (sample !== 4'd0) nz++;
      if (sample_valid === 1'b1) pulses++;
    end
    tests++; if (nz != 0) begin fails++; $display("FAIL mute_nonzero got=%0d exp=0", nz); end
    tests++; if (pulses != 100) begin fails++; $display("FAIL valid_rate got=%0d exp=100", pulses); end
    $display("[TB] test_period_mute done");
  endtask

  task automatic test_envelope();
    int k, exp_decay, nz;
    logic [3:0] last;
    do_reset();
    wr(2'd0, 8'hC0); wr(2'd2, 8'h08); wr(2'd3, 8'h08);
    exp_decay = 15; last = 4'd0; k = 0;
    while (exp_decay > 0 && k < 17 * QF) begin
      @(negedge CLK); k++;
      if (sample !== 4'd0 && sample !== last) begin
        tests++;
        if (sample !== 4'(exp_decay)) begin
          fails++; $display("FAIL env_decay got=%0d exp=%0d", sample, exp_decay);
        end
        last = sample;
        exp_decay--;
      end
    end
    tests++; if (exp_decay != 0) begin fails++; $display("FAIL env_timeout got=%0d exp=0", exp_decay); end
    repeat (QF + 200) @(negedge CLK);
    nz = 0;
    repeat (2 * QF) begin @(negedge CLK); if (sample !== 4'd0) nz++; end
    tests++; if (nz != 0) begin fails++; $display("FAIL env_hold_zero got=%0d exp=0", nz); end
    $display("[TB] test_envelope done");
  endtask

  task automatic test_length();
    int k, drops;
    wr(2'd0, 8'h1F); wr(2'd3, 8'h18);
    tests++; if (length_active !== 1'b1) begin fails++; $display("FAIL len_load got=%b exp=1", length_active); end
    k = 0;
    while (length_active === 1'b1 && k < 3 * HF) begin @(negedge CLK); k++; end
    tests++;
    if (k <= HF || k > 2 * HF) begin fails++; $display("FAIL len_expire got=%0d exp=%0d..%0d", k, HF + 1, 2 * HF); end
    // Next half frame is exactly HF clocks after the one that emptied the counter.
    repeat (HF - 1) @(negedge CLK);
    wr(2'd3, 8'h18);
    k = 0;
    while (length_active === 1'b1 && k < 3 * HF) begin @(negedge CLK); k++; end
    tests++; if (k != 2 * HF) begin fails++; $display("FAIL len_load_skip got=%0d exp=%0d", k, 2 * HF); end
    wr(2'd0, 8'h3F); wr(2'd3, 8'h18);
    drops = 0;
    repeat (2 * HF + HF / 2) begin @(negedge CLK); if (length_active !== 1'b1) drops++; end
    tests++; if (drops != 0) begin fails++; $display("FAIL len_halt got=%0d exp=0", drops); end
    $display("[TB] test_length done");
  endtask

  task automatic test_enable();
    int bad_len, bad_smp;
    enable = 1'b0;
    @(negedge CLK);
    tests++; if (length_active !== 1'b0) begin fails++; $display("FAIL en_clear got=%b exp=0", length_active); end
    wr(2'd3, 8'h08);
    repeat (CPU_DIV) @(negedge CLK);
    bad_len = 0; bad_smp = 0;
    repeat (200) begin
      @(negedge CLK);
      if (length_active !== 1'b0) bad_len++;
      if (sample !== 4'd0) bad_smp++;
    end
    tests++; if (bad_len != 0) begin fails++; $display("FAIL en_noload got=%0d exp=0", bad_len); end
    tests++; if (bad_smp != 0) begin fails++; $display("FAIL en_sample got=%0d exp=0", bad_smp); end
    enable = 1'b1;
    wr(2'd0, 8'hBF); wr(2'd2, 8'h10); wr(2'd3, 8'h08);
    tests++; if (length_active !== 1'b1) begin fails++; $display("FAIL en_reload got=%b exp=1", length_active); end
    repeat (50) @(negedge CLK);
    enable = 1'b0;
    @(negedge CLK);
    tests++; if (length_active !== 1'b0) begin fails++; $display("FAIL en_drop got=%b exp=0", length_active); end
    enable = 1'b1;
    $display("[TB] test_enable done");
  endtask

  task automatic test_async_reset();
    int k;
    wr(2'd0, 8'hBF); wr(2'd2, 8'h10); wr(2'd3, 8'h08);
    k = 0;
    while (sample !== 4'd15 && k < 3000) begin @(negedge CLK); k++; end
    tests++; if (sample !== 4'd15) begin fails++; $display("FAIL arst_note got=%0d exp=15", sample); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (sample !== 4'd0) begin fails++; $display("FAIL arst_sample got=%0d exp=0", sample); end
    tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL arst_valid got=%b exp=0", sample_valid); end
    tests++; if (length_active !== 1'b0) begin fails++; $display("FAIL arst_len got=%b exp=0", length_active); end
    repeat (2) @(negedge CLK);
    reset_n = 1'b1;
    for (int i = 1; i <= CPU_DIV; i++) begin
      @(negedge CLK);
      tests++;
      if (sample_valid !== (i == CPU_DIV)) begin
        fails++; $display("FAIL arst_first_tick clk=%0d got=%b exp=%b", i, sample_valid, i == CPU_DIV);
      end
    end
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_duty_pattern();
    test_period_mute();
    test_envelope();
    test_length();
    test_enable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
